// File: rtl/div_sequencer.sv
// Request sequencer in front of a start/done divider. Requests are buffered in a FIFO,
// issued one at a time, and returned in order. Divide-by-zero is answered locally.
module div_sequencer #(
    parameter int BITS  = 16,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_dividend,
    input  logic [BITS-1:0]  in_divisor,
    input  logic [TAG_W-1:0] in_tag,

    output logic             div_start,
    output logic [BITS-1:0]  div_dividend,
    output logic [BITS-1:0]  div_divisor,
    input  logic             div_done,
    input  logic [BITS-1:0]  div_quotient,
    input  logic [BITS-1:0]  div_remainder,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_quotient,
    output logic [BITS-1:0]  out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div0,

    output logic             busy
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 2 * BITS + TAG_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [ENTRY_W-1:0] r_fifo_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    logic [ENTRY_W-1:0] w_head;
    logic [BITS-1:0]    w_head_dividend;
    logic [BITS-1:0]    w_head_divisor;
    logic [TAG_W-1:0]   w_head_tag;
    logic               w_head_div0;

    logic [BITS-1:0]    r_op_dividend;
    logic [BITS-1:0]    r_op_divisor;
    logic [TAG_W-1:0]   r_op_tag;

    logic [BITS-1:0]    r_out_quotient;
    logic [BITS-1:0]    r_out_remainder;
    logic [TAG_W-1:0]   r_out_tag;
    logic               r_out_div0;

    // Full/empty come from registered occupancy only, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign w_full   = (r_count == (PTR_W + 1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;

    assign w_head          = r_fifo_mem[r_rd_ptr];
    assign w_head_dividend = w_head[ENTRY_W-1 -: BITS];
    assign w_head_divisor  = w_head[TAG_W +: BITS];
    assign w_head_tag      = w_head[TAG_W-1:0];
    assign w_head_div0     = (w_head_divisor == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {in_dividend, in_divisor, in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_next = w_head_div0 ? S_HOLD : S_ISSUE;
                end
            end
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (div_done) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        div_start = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_pop     = !w_empty;
            S_ISSUE: div_start = 1'b1;
            S_HOLD:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Zero divisors are resolved at pop time and go straight to the result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_dividend   <= '0;
            r_op_divisor    <= '0;
            r_op_tag        <= '0;
            r_out_quotient  <= '0;
            r_out_remainder <= '0;
            r_out_tag       <= '0;
            r_out_div0      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op_dividend <= w_head_dividend;
                r_op_divisor  <= w_head_divisor;
                r_op_tag      <= w_head_tag;
                if (w_head_div0) begin
                    r_out_quotient  <= '1;
                    r_out_remainder <= w_head_dividend;
                    r_out_tag       <= w_head_tag;
                    r_out_div0      <= 1'b1;
                end
            end
            if ((r_state == S_WAIT) && div_done) begin
                r_out_quotient  <= div_quotient;
                r_out_remainder <= div_remainder;
                r_out_tag       <= r_op_tag;
                r_out_div0      <= 1'b0;
            end
        end
    end

    assign div_dividend  = r_op_dividend;
    assign div_divisor   = r_op_divisor;
    assign out_quotient  = r_out_quotient;
    assign out_remainder = r_out_remainder;
    assign out_tag       = r_out_tag;
    assign out_div0      = r_out_div0;
    assign busy          = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: divider stub, in-order scoreboard,
// directed scenarios with literal expectations, then a randomized run.
module tb_div_sequencer;

    localparam int BITS  = 16;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [BITS-1:0]  in_dividend;
    logic [BITS-1:0]  in_divisor;
    logic [TAG_W-1:0] in_tag;
    logic             div_start;
    logic [BITS-1:0]  div_dividend;
    logic [BITS-1:0]  div_divisor;
    logic             div_done;
    logic [BITS-1:0]  div_quotient;
    logic [BITS-1:0]  div_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [BITS-1:0]  out_quotient;
    logic [BITS-1:0]  out_remainder;
    logic [TAG_W-1:0] out_tag;
    logic             out_div0;
    logic             busy;

    always #5 clk = ~clk;

    div_sequencer #(.BITS(BITS), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_tag(out_tag), .out_div0(out_div0), .busy(busy)
    );

    typedef struct packed {
        logic [BITS-1:0]  a;
        logic [BITS-1:0]  b;
        logic [TAG_W-1:0] t;
    } req_t;

    typedef struct packed {
        logic [BITS-1:0]  q;
        logic [BITS-1:0]  r;
        logic [TAG_W-1:0] t;
        logic             d0;
    } res_t;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Divider stub: random latency, one-cycle done, garbage on the result bus otherwise.
    logic            dv_busy      = 1'b0;
    logic            dv_abandon   = 1'b0;
    logic            dv_last_real = 1'b0;
    logic            spur_en      = 1'b0;
    logic [BITS-1:0] dv_a;
    logic [BITS-1:0] dv_b;
    int              dv_cnt       = 0;
    int              lat_min      = 0;
    int              lat_max      = 5;
    int              dv_starts    = 0;

    initial begin
        div_done      = 1'b0;
        div_quotient  = '0;
        div_remainder = '0;
        forever begin
            @(negedge clk);
            if (dv_last_real && rst_n) chk("done_to_out_valid", out_valid, 1);
            dv_last_real = 1'b0;
            if (!rst_n) dv_abandon = 1'b1;
            div_done      = 1'b0;
            div_quotient  = 16'($urandom);
            div_remainder = 16'($urandom);
            if (rst_n && div_start) begin
                chk("single_in_flight", dv_busy && !dv_abandon, 0);
                chk("start_zero_divisor", div_divisor == '0, 0);
                dv_a       = div_dividend;
                dv_b       = div_divisor;
                dv_busy    = 1'b1;
                dv_abandon = 1'b0;
                dv_cnt     = $urandom_range(lat_max, lat_min);
                dv_starts++;
            end else if (dv_busy) begin
                if (!dv_abandon && rst_n) begin
                    chk("operand_a_stable", div_dividend, dv_a);
                    chk("operand_b_stable", div_divisor, dv_b);
                end
                if (dv_cnt == 0) begin
                    div_done      = 1'b1;
                    div_quotient  = (dv_b == '0) ? '1 : dv_a / dv_b;
                    div_remainder = (dv_b == '0) ? dv_a : dv_a % dv_b;
                    dv_busy       = 1'b0;
                    dv_last_real  = !dv_abandon && rst_n;
                end else begin
                    dv_cnt--;
                end
            end else if (spur_en && ($urandom_range(7, 0) == 0)) begin
                div_done = 1'b1;
            end
        end
    end

    // Scoreboard: every accepted request must come back once, in order.
    req_t exp_q[$];
    res_t got_q[$];
    logic prev_hold = 1'b0;
    logic prev_acc  = 1'b0;
    res_t prev_out;

    always @(negedge clk) begin
        req_t e;
        res_t w;
        res_t cur;
        cur = {out_quotient, out_remainder, out_tag, out_div0};
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            chk("busy", busy, exp_q.size() != 0);
            chk("queue_bound", exp_q.size() <= DEPTH + 1, 1);
            if (exp_q.size() < DEPTH) chk("in_ready_not_full", in_ready, 1);
            else if (exp_q.size() > DEPTH) chk("in_ready_full", in_ready, 0);
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_stable", cur, prev_out);
            end
            if (prev_acc) chk("bubble_after_accept", out_valid, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.b == '0) w = {16'hFFFF, e.a, e.t, 1'b1};
                    else           w = {e.a / e.b, e.a % e.b, e.t, 1'b0};
                    chk("result", cur, w);
                    $display("RESULT tag=%0d %0d/%0d q=%0d r=%0d div0=%0d",
                             cur.t, e.a, e.b, cur.q, cur.r, cur.d0);
                end
                got_q.push_back(cur);
            end
            if (in_valid && in_ready) exp_q.push_back({in_dividend, in_divisor, in_tag});
            prev_hold = out_valid && !out_ready;
            prev_acc  = out_valid && out_ready;
            prev_out  = cur;
        end
    end

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic push(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic [TAG_W-1:0] t);
        int n = 0;
        in_dividend = a;
        in_divisor  = b;
        in_tag      = t;
        in_valid    = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n > 0) stalls++;
        chk("push_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        @(negedge clk);
        while (got_q.size() < n && k < 600) begin
            k++;
            @(negedge clk);
        end
        chk("result_count", got_q.size(), n);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 1000) begin
            k++;
            @(negedge clk);
        end
        chk("idle_timeout", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_in_ready"}, in_ready, 1);
        chk({p, "_div_start"}, div_start, 0);
        chk({p, "_out_valid"}, out_valid, 0);
        chk({p, "_out_div0"}, out_div0, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_out_quotient"}, out_quotient, 0);
        chk({p, "_out_remainder"}, out_remainder, 0);
        chk({p, "_out_tag"}, out_tag, 0);
        chk({p, "_div_dividend"}, div_dividend, 0);
        chk({p, "_div_divisor"}, div_divisor, 0);
    endtask

    function automatic logic [BITS-1:0] rnd_divisor();
        int s;
        s = $urandom_range(9, 0);
        if (s < 2) return '0;
        if (s < 5) return 16'($urandom_range(15, 1));
        return 16'($urandom);
    endfunction

    function automatic logic [BITS-1:0] rnd_dividend();
        if ($urandom_range(1, 0) == 0) return 16'($urandom_range(40, 0));
        return 16'($urandom);
    endfunction

    initial begin
        int   s0;
        int   k;
        int   sent;
        logic acc [6];

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;

        // Single request 11/3: pop one edge after the push, start one cycle later.
        out_ready = 1'b1;
        got_q.delete();
        s0 = dv_starts;
        push(11, 3, 5);
        @(negedge clk);
        chk("t1_no_start_yet", div_start, 0);
        @(negedge clk);
        chk("t1_start_pulse", div_start, 1);
        @(posedge clk); #1;
        wait_got(1);
        chk("t1_q", got_q[0].q, 3);
        chk("t1_r", got_q[0].r, 2);
        chk("t1_tag", got_q[0].t, 5);
        chk("t1_div0", got_q[0].d0, 0);
        chk("t1_starts", dv_starts - s0, 1);

        // Back-to-back pushes never see in_ready low.
        wait_idle();
        got_q.delete();
        stalls = 0;
        push(100, 7, 0);
        push(65535, 255, 1);
        push(9, 10, 2);
        push(1, 1, 3);
        wait_got(4);
        chk("t2_stalls", stalls, 0);
        chk("t2_q0", {got_q[0].q, got_q[0].r, got_q[0].t}, {16'd14, 16'd2, 4'd0});
        chk("t2_q1", {got_q[1].q, got_q[1].r, got_q[1].t}, {16'd257, 16'd0, 4'd1});
        chk("t2_q2", {got_q[2].q, got_q[2].r, got_q[2].t}, {16'd0, 16'd9, 4'd2});
        chk("t2_q3", {got_q[3].q, got_q[3].r, got_q[3].t}, {16'd1, 16'd0, 4'd3});

        // Fill: 4 FIFO entries plus one held by the sequencer, sixth refused.
        wait_idle();
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_dividend = 16'(1000 + i * 37);
            in_divisor  = 16'(i + 3);
            in_tag      = 4'(8 + i);
            in_valid    = 1'b1;
            @(negedge clk);
            acc[i] = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) chk($sformatf("t3_accept%0d", i), acc[i], i < 5);
        out_ready = 1'b1;
        push(16'(1000 + 5 * 37), 8, 13);
        wait_got(6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_tag%0d", i), got_q[i].t, 8 + i);

        // Zero divisor answered locally, out_valid after the second edge.
        wait_idle();
        got_q.delete();
        s0 = dv_starts;
        push(1234, 0, 7);
        @(negedge clk);
        chk("t4_valid_early", out_valid, 0);
        @(negedge clk);
        chk("t4_valid", out_valid, 1);
        chk("t4_q", out_quotient, 16'hFFFF);
        chk("t4_r", out_remainder, 1234);
        chk("t4_div0", out_div0, 1);
        chk("t4_tag", out_tag, 7);
        @(posedge clk); #1;
        wait_got(1);
        chk("t4_starts", dv_starts - s0, 0);

        // Consumer stalls 20 cycles: result frozen, next request not issued.
        wait_idle();
        got_q.delete();
        out_ready = 1'b0;
        push(40, 3, 1);
        push(41, 5, 2);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk("t5_valid_timeout", out_valid, 1);
        s0 = dv_starts;
        repeat (20) @(negedge clk);
        chk("t5_still_valid", out_valid, 1);
        chk("t5_no_new_start", dv_starts - s0, 0);
        chk("t5_q", {out_quotient, out_remainder, out_tag}, {16'd13, 16'd1, 4'd1});
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_got(2);
        chk("t5_second", {got_q[1].q, got_q[1].r, got_q[1].t}, {16'd8, 16'd1, 4'd2});

        // Reset during WAIT with two queued; late done must be ignored.
        wait_idle();
        lat_min = 10;
        lat_max = 10;
        push(200, 7, 4);
        push(300, 9, 5);
        push(400, 11, 6);
        k = 0;
        @(negedge clk);
        while (!dv_busy && k < 50) begin
            k++;
            @(negedge clk);
        end
        chk("t6_issued", dv_busy, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("t6");
        k = 0;
        while (dv_busy && k < 50) begin
            k++;
            @(negedge clk);
        end
        chk("t6_late_done_fired", dv_busy, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_valid_after_late_done", out_valid, 0);
        end
        lat_min = 0;
        lat_max = 5;
        @(posedge clk); #1;
        got_q.delete();
        push(50, 6, 3);
        wait_got(1);
        chk("t6_fresh", {got_q[0].q, got_q[0].r, got_q[0].t, got_q[0].d0}, {16'd8, 16'd2, 4'd3, 1'b0});

        // Randomized traffic with back-pressure and spurious done pulses.
        wait_idle();
        spur_en = 1'b1;
        sent = 0;
        k = 0;
        while (sent < 250 && k < 20000) begin
            in_valid    = ($urandom_range(3, 0) != 0);
            in_dividend = rnd_dividend();
            in_divisor  = rnd_divisor();
            in_tag      = 4'($urandom);
            out_ready   = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("random_sent", sent, 250);
        wait_idle();
        spur_en = 1'b0;
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Request sequencer placed directly upstream of the non-restoring divider (`divider_nr`). It accepts division requests over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to the divider's `start`/`done` interface and returns tagged quotient/remainder results over a second valid/ready handshake. Divide-by-zero requests are resolved locally and never reach the divider.

## Interface
- `BITS`, 16: operand and result width; must match the divider's `BITS`.
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the opaque request tag carried to the result.

Clock and reset are fixed: one clock `clk`; reset `rst_n` is synchronous and active-low.

- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  request FIFO can accept
- `in_dividend`  in  BITS  unsigned dividend
- `in_divisor`  in  BITS  unsigned divisor
- `in_tag`  in  TAG_W  request tag
- `div_start`  out  1  one-cycle start pulse to divider
- `div_dividend`  out  BITS  operand to divider, stable from start until done
- `div_divisor`  out  BITS  operand to divider, stable from start until done
- `div_done`  in  1  divider completion
- `div_quotient`  in  BITS  divider quotient, valid with `div_done`
- `div_remainder`  in  BITS  divider remainder, valid with `div_done`
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer accepts result
- `out_quotient`  out  BITS  result quotient
- `out_remainder`  out  BITS  result remainder
- `out_tag`  out  TAG_W  tag of originating request
- `out_div0`  out  1  result came from a zero-divisor request
- `busy`  out  1  FIFO non-empty or state ≠ IDLE

## Operation
- FIFO: `DEPTH` entries of {dividend, divisor, tag}. Push on `in_valid && in_ready`. `in_ready = !full`, registered-state based only: a push is refused when the FIFO is full, even if a pop occurs the same cycle.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into operand/tag registers.
    - divisor == 0 → HOLD with quotient = all ones, remainder = dividend, `out_div0` = 1.
    - otherwise → ISSUE.
  - ISSUE: `div_start` = 1 for exactly this cycle → WAIT.
  - WAIT: on the first cycle `div_done` = 1, capture `div_quotient`/`div_remainder` into output registers with `out_div0` = 0 → HOLD.
  - HOLD: `out_valid` = 1; outputs frozen while `out_ready` = 0; on `out_ready` = 1 → IDLE.
- `div_done` is ignored outside WAIT. No timeout.
- `div_dividend`/`div_divisor` are driven from the operand registers and change only on a pop.
- Strict in-order completion; at most one request in the divider.
- Width rules: all arithmetic is unsigned, no extension; the tag passes through unmodified.

## Timing
- Reset values (cycle after `rst_n` = 0 sampled):
  - state IDLE, FIFO empty.
  - `in_ready` 1; `div_start` 0; `out_valid` 0; `out_div0` 0; `busy` 0.
  - `out_quotient`, `out_remainder`, `out_tag`, `div_dividend`, `div_divisor` all 0.
- Push at edge N, FSM idle: pop at edge N+1, `div_start` high during cycle N+1→N+2.
- `div_done` sampled high at edge M: `out_valid` high from M, i.e. one cycle after the done cycle.
- Zero divisor: push at N → `out_valid` high after edge N+1; the divider is untouched.
- Result accepted at edge K (`out_valid && out_ready`): state IDLE after K. The next pop is at K+1, so there is one bubble cycle between results.
- Reset mid-operation: FIFO contents and any in-flight result are discarded. A late `div_done` is ignored, since the state is IDLE. The divider must accept a new `start` at any time, abandoning its current operation.
- Simultaneous push and pop while non-empty: both occur, and the count is unchanged.

## Test plan
- Single request 11/3, tag 5, `out_ready` = 1 → one `div_start` pulse; result Q = 3, R = 2, tag 5, `out_div0` = 0.
- Back-to-back pushes of 100/7, 65535/255, 9/10, 1/1 with tags 0–3 → `in_ready` stays 1. Results in order: (14, 2), (257, 0), (0, 9), (1, 0).
- Push 6 requests with `DEPTH` = 4 while `out_ready` = 0 → `in_ready` drops after 4 entries plus 1 in flight. No lost or duplicated tag after `out_ready` is released.
- Zero divisor 1234/0, tag 7 → `out_valid` 2 cycles after push; Q = 0xFFFF, R = 1234, `out_div0` = 1; `div_start` never asserts.
- `out_ready` held 0 for 20 cycles in HOLD → outputs and `out_valid` stable; next `div_start` waits for acceptance.
- `rst_n` low for 1 cycle during WAIT with 2 queued → all outputs at reset values. The subsequent `div_done` produces no `out_valid`; a fresh request 50/6 returns Q = 8, R = 2.
